// File: rtl/cdc_pkg.sv
// cdc_pkg: shared limits and helpers for the clock-domain-crossing input blocks
package cdc_pkg;
  localparam int CDC_MIN_STAGES = 2;
  localparam int CDC_MIN_FILTER = 1;
  function automatic int cnt_width(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction
endpackage

// File: rtl/cdc_glitch_filter.sv
// cdc_glitch_filter: single-bit stability filter with registered rise/fall pulses
module cdc_glitch_filter
  import cdc_pkg::*;
#(
  parameter int   FILTER_CYCLES = 1,
  parameter logic RESET_BIT     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic s_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
  if (FILTER_CYCLES < CDC_MIN_FILTER) begin : g_bad_filter
    $error("cdc_glitch_filter: FILTER_CYCLES must be >= %0d", CDC_MIN_FILTER);
  end
  logic [CW-1:0] cnt, cnt_d;
  logic diff, hit, q_d;
  always_comb begin
    diff  = s_i != q_o;
    hit   = diff && cnt == LAST;
    q_d   = hit ? s_i : q_o;
    cnt_d = (!diff || hit) ? '0 : cnt + CW'(1);
  end
  // pulses are registered alongside q_o so they align with the new level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o    <= RESET_BIT;
      cnt    <= '0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      q_o    <= q_d;
      cnt    <= cnt_d;
      rise_o <= q_d & ~q_o;
      fall_o <= ~q_d & q_o;
    end
  end
endmodule

// File: rtl/cdc_sync_filter.sv
// cdc_sync_filter: per-bit synchronizer chain followed by glitch filter and edge pulses
module cdc_sync_filter
  import cdc_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 1,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);
  if (STAGES < CDC_MIN_STAGES) begin : g_bad_stages
    $error("cdc_sync_filter: STAGES must be >= %0d", CDC_MIN_STAGES);
  end
  if (FILTER_CYCLES < CDC_MIN_FILTER) begin : g_bad_filter
    $error("cdc_sync_filter: FILTER_CYCLES must be >= %0d", CDC_MIN_FILTER);
  end
  (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
  logic [STAGES-1:0][WIDTH-1:0] sync;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync <= {STAGES{RESET_VAL}};
    else sync <= {sync[STAGES-2:0], d_i};
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cdc_glitch_filter #(
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_BIT    (RESET_VAL[i])
    ) u_filter (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .s_i   (sync[STAGES-1][i]),
      .q_o   (q_o[i]),
      .rise_o(rise_o[i]),
      .fall_o(fall_o[i])
    );
  end
endmodule
